// File: rtl/temporizador_pkg.sv
// temporizador_pkg
// Shared definitions for the down-counting timer.
//   state_e    : timer FSM encoding (IDLE / RUN / DONE)
//   DEF_WIDTH  : default counter and preset width
package temporizador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/temporizador_descendente.sv
// temporizador_descendente
// Loadable down-counting timer with one-shot and periodic (auto-reload) modes.
// A preset is captured into a reload register. On start, the preset is copied into
// count. The count then decrements on enabled ticks. Reaching zero raises a
// terminal-count pulse. It also raises a done pulse unless the timer reloads.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   enable             : tick qualifier, one decrement per enabled cycle
//   load, load_value   : write the reload register (IDLE/DONE only)
//   start, stop        : begin a count / abort a running count
//   auto_reload        : 1 = periodic, 0 = one-shot (sampled every cycle)
//   count              : current count (registered)
//   tc, done           : one-cycle terminal-count / one-shot completion pulses
//   busy, expired      : state levels for RUN / DONE
module temporizador_descendente
  import temporizador_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done,
  output logic             busy,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] start_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    tc_d      = 1'b0;
    done_d    = 1'b0;
    // A same-cycle load overrides the stored reload value for this start.
    start_val = load ? load_value : reload_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (load) reload_d = load_value;
        if (start) begin
          count_d = start_val;
          if (start_val == ZERO) begin
            // A zero preset completes at once. No tick was consumed, so no tc is raised.
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (enable) begin
          if (count_q > ONE) begin
            count_d = count_q - ONE;
          end else if (count_q == ONE) begin
            count_d = ZERO;
            tc_d    = 1'b1;
            if (!auto_reload) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else if (auto_reload) begin
            // Periodic mode spends one extra tick at zero, so the period is R+1.
            count_d = reload_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign done    = done_q;
  assign busy    = (state_q == RUN);
  assign expired = (state_q == DONE);

endmodule

// File: doc/temporizador_descendente.md
# temporizador_descendente

Programmable, loadable down-counting timer: the counterpart of the free-running 8-bit up counter. It is preset with a value, started, and counts down on qualified ticks. It reports expiry with a terminal-count pulse, and optionally reloads for periodic operation. In the timing subsystem its `enable` is typically driven by an upstream up-counter's `tc`, which makes it a programmable divider or one-shot.

## Interface
- `WIDTH`, 8, counter and preset width.

- `clk` in 1: clock; all state changes on its rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `enable` in 1: tick qualifier; a decrement occurs only in cycles where `enable`=1.
- `load` in 1: capture `load_value` into the reload register.
- `load_value` in WIDTH: preset value.
- `start` in 1: begin a count from the reload value.
- `stop` in 1: abort a running count.
- `auto_reload` in 1: 1 = periodic mode, 0 = one-shot mode; sampled live every cycle.
- `count` out WIDTH: current count, registered.
- `tc` out 1: one-cycle pulse, high during the first cycle `count` reads 0 after a decrement.
- `done` out 1: one-cycle pulse when a one-shot completes.
- `busy` out 1: high while in RUN.
- `expired` out 1: level, high while in DONE.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: IDLE, `count`=0, reload register=0, `tc`=0, `done`=0, `busy`=0, `expired`=0.

- Load:
  - `load` in IDLE or DONE writes the reload register.
  - `load` in RUN is ignored.

- Start from IDLE or DONE:
  - `count` is set from the reload register, or from `load_value` if `load` is asserted in the same cycle.
  - The state goes to RUN.
  - If that value is 0, the state goes directly to DONE with a `done` pulse and no `tc`, regardless of `auto_reload`.
  - `start` in RUN is ignored.

- RUN, priority order:
  1. `stop`: go to IDLE, hold `count`, no `tc`, no `done`.
  2. `enable` and `count`>1: decrement `count`.
  3. `enable` and `count`=1: `count` becomes 0 and `tc` pulses. If `auto_reload`=0, also go to DONE with a `done` pulse.
  4. `enable` and `count`=0 (auto-reload only): `count` is set from the reload register; no `tc`.
  5. `enable`=0: hold.

- Periods:
  - Periodic mode: one `tc` every R+1 enabled ticks.
  - One-shot mode: `done` after R enabled ticks.
- Clearing `auto_reload` mid-run makes the next terminal event a one-shot completion.
- DONE: `count` holds 0; leave only via `start` or `reset`.
- Decrement is unsigned modulo 2^WIDTH. `count` can never underflow given the rules above.
- `reset` asserted mid-operation forces the reset values immediately, without waiting for a clock edge.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `start` sampled at edge N gives `busy`=1 and `count`=R visible after edge N. The `enable` in that start cycle does not decrement.
- With `enable` held high and R≥1, `tc` and `done` are high in the cycle after edge N+R.
- In periodic mode `count` reads R, R-1, …, 1, 0, R, …
- `done` and `tc` are each high for exactly one cycle per event.
- `busy` falls on the same edge that raises `done`, or on the edge that takes `stop`.

## Structure
- Package `temporizador_pkg` holds:
  - the state typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the default WIDTH constant.
- Single module with no sub-module: one state register block plus the count and reload registers.
- Estimated size: about 150 lines of RTL.

## Test plan
- Reset, then load 5 and start with `enable`=1: `count` reads 5,4,3,2,1,0. `tc` and `done` pulse together, once, 6 cycles after `start`. `expired`=1 afterwards.
- `auto_reload`=1, R=3, `enable`=1 for 12 cycles: `count` reads 3,2,1,0,3,2,1,0,…; `tc` every 4 cycles; `done` never pulses.
- `enable` toggling 1,0,1,0 with R=2: decrements occur only on enabled cycles; `tc` arrives 4 cycles after `start`.
- Assert `stop` with `count`=3: state IDLE, `count` holds 3, no `tc` and no `done`. A following `start` reloads R.
- Load 0 and start: `done` pulses in the next cycle, `tc` stays 0, `busy` never goes high.
- `load` asserted during RUN is ignored. `reset` pulsed asynchronously mid-count: all outputs read 0 immediately, state IDLE.
